ab_step_monitor: RTL
====================

# ab_step_monitor

Downstream consumer of the two-bit sequential counter's state outputs A and B. Samples {A,B} every clock and classifies each change as an up step, a down step, a hold, or an illegal jump. Maintains a wrapping position count, a revolution count, a stall flag and a sticky error record. Its outputs drive the week's display/scoreboard logic and let a bench check the counter's E/x behaviour without hand-decoding waveforms.

## Interface
- POS_W, 8: position counter width.
- REV_W, 4: revolution counter width.
- ERR_W, 4: error counter width (saturating).
- STALL_CYCLES, 8: consecutive hold samples before stall asserts (legal range ≥1).

- clk  in  1  rising-edge clock, same clock as the upstream counter.
- reset  in  1  asynchronous, active-high; all state cleared while high.
- A  in  1  upstream state MSB (sampled, no synchroniser; same clock domain).
- B  in  1  upstream state LSB.
- clr  in  1  synchronous clear of counters, error and FSM.
- step  out  1  one-cycle pulse: a legal step was seen this sample.
- dir  out  1  direction of last legal step (1 = up, 0 = down).
- position  out  POS_W  net step count, mod 2^POS_W.
- revs  out  REV_W  net revolution count, mod 2^REV_W.
- stall  out  1  level: STALL_CYCLES consecutive holds seen.
- err  out  1  sticky: at least one illegal jump since reset/clr.
- err_count  out  ERR_W  illegal jump count, saturates at 2^ERR_W−1.

## Operation
- cur = {A,B}; prev = registered previous sample; delta = (cur − prev) mod 4.
- FSM states: INIT, TRACK, STALLED.
  - INIT: capture prev ← cur; no classification; next TRACK.
  - TRACK/STALLED: classify delta each edge, then prev ← cur.
- delta 0 (hold): hold_cnt += 1 (saturating at STALL_CYCLES). In TRACK, when the incremented value equals STALL_CYCLES → STALLED.
- delta 1 (up): step=1, dir=1, position += 1; if prev=3 and cur=0, revs += 1. hold_cnt ← 0; → TRACK.
- delta 3 (down): step=1, dir=0, position −= 1; if prev=0 and cur=3, revs −= 1. hold_cnt ← 0; → TRACK.
- delta 2 (jump): err ← 1, err_count += 1 (saturating). position, revs and dir are unchanged; step=0. hold_cnt ← 0; → TRACK.
- stall = 1 exactly while in STALLED.
- position and revs wrap modulo their widths; no overflow flag.
- clr (synchronous): position, revs, err, err_count, hold_cnt, dir ← 0; FSM → INIT. clr wins over any simultaneous step or jump. prev is recaptured on the following INIT edge.

## Timing
- All outputs are registered. A sample taken at rising edge k is reflected in the outputs immediately after edge k (one-edge latency from the {A,B} value present before edge k).
- step is high for exactly one cycle per legal step. Back-to-back steps give back-to-back pulses.
- Reset (async assert, any time, including mid-stall or mid-error): step=0, dir=0, position=0, revs=0, stall=0, err=0, err_count=0, hold_cnt=0, prev=0, FSM=INIT.
- First edge after reset or clr is INIT: no step, hold or jump is ever reported for it.
- Upstream hold (E=0) produces delta 0 every cycle. With STALL_CYCLES=8, stall rises on the 8th consecutive hold edge after the last activity.
- Leaving STALLED: stall falls at the same edge the step or jump is classified.

## Test plan
- Reset, then {A,B} = 00,01,10,11,00 on successive edges → four step pulses, dir=1, position=4, revs=1, err=0.
- After reset, {A,B} = 00,11,10 → two step pulses, dir=0, position=8'hFE, revs=4'hF (revs decrements on the 0→3 step).
- Jump 00→10 after INIT → err=1, err_count=1, step=0, position unchanged. A further 16 alternating jumps (10↔00) → err_count holds at 15.
- Hold {A,B}=01 for 10 edges after a step → stall=0 through the 7th hold edge and 1 from the 8th. The next 01→10 edge gives stall=0, step=1.
- Drive the upstream counter with E=1, x=1 for 20 ns, then E=1, x=0 for 20 ns (4 ns clock). Position must match the upstream transition count in each phase and err must stay 0.
- Assert reset asynchronously mid-stream (position=5, err=1) → all outputs 0 immediately. Assert clr simultaneous with an up step → outputs cleared, no step pulse, next edge is INIT.

Source files
------------

// File: rtl/ab_step_monitor.sv
// Watches the two-bit {A,B} counter state and decodes each sample into up/down steps,
// holds and illegal jumps, tracking position, revolutions, stall and error history.
module ab_step_monitor #(
    parameter int POS_W        = 8,
    parameter int REV_W        = 4,
    parameter int ERR_W        = 4,
    parameter int STALL_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] position,
    output logic [REV_W-1:0] revs,
    output logic             stall,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_TRACK   = 2'd1;
    localparam logic [1:0] S_STALLED = 2'd2;

    localparam int              HOLD_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STALL_CYCLES);

    logic [1:0]        state;
    logic [1:0]        prev;
    logic [1:0]        cur;
    logic [1:0]        delta;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_inc;

    assign cur      = {A, B};
    assign delta    = cur - prev;
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
    // stall is a pure decode of the state register, so it is still glitch-free and registered.
    assign stall    = (state == S_STALLED);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others; blocking would chain updates within one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            prev      <= 2'd0;
            hold_cnt  <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            position  <= '0;
            revs      <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            step <= 1'b0;
            if (clr) begin
                state     <= S_INIT;
                hold_cnt  <= '0;
                dir       <= 1'b0;
                position  <= '0;
                revs      <= '0;
                err       <= 1'b0;
                err_count <= '0;
            end else if (state == S_INIT) begin
                prev  <= cur;
                state <= S_TRACK;
            end else begin
                prev <= cur;
                case (delta)
                    2'd0: begin
                        hold_cnt <= hold_inc;
                        if (state == S_TRACK && hold_inc == HOLD_MAX)
                            state <= S_STALLED;
                    end
                    2'd1: begin
                        step     <= 1'b1;
                        dir      <= 1'b1;
                        position <= position + POS_W'(1);
                        if (prev == 2'd3 && cur == 2'd0)
                            revs <= revs + REV_W'(1);
                        hold_cnt <= '0;
                        state    <= S_TRACK;
                    end
                    2'd3: begin
                        step     <= 1'b1;
                        dir      <= 1'b0;
                        position <= position - POS_W'(1);
                        if (prev == 2'd0 && cur == 2'd3)
                            revs <= revs - REV_W'(1);
                        hold_cnt <= '0;
                        state    <= S_TRACK;
                    end
                    default: begin
                        err <= 1'b1;
                        if (err_count != {ERR_W{1'b1}})
                            err_count <= err_count + ERR_W'(1);
                        hold_cnt <= '0;
                        state    <= S_TRACK;
                    end
                endcase
            end
        end
    end

endmodule
